// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory controller: turns MemRead/MemWrite into a req/ack
// transaction, stalls the pipeline while it is outstanding, and gates write-back.
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TO_W    = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] ALUResult_i,
  input  logic [31:0] WRData_i,
  input  logic        RegWrite_i,
  input  logic        MemToReg_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic [31:0] RDData_o,
  output logic        RegWrite_o,
  output logic        MemToReg_o,
  output logic        stall_o,
  output logic        bus_err_o
);

  localparam int unsigned DW = 32;
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_BUSY = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;
  localparam logic            TO_EN   = (TIMEOUT != 0);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  logic [1:0]    state_q, state_d;
  logic          req_q, req_d;
  logic          we_q, we_d;
  logic [DW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          acc;
  logic [1:0]    unused_addr_lsb;

  assign acc             = MemRead_i | MemWrite_i;
  // Word-aligned bus: byte offset is intentionally dropped.
  assign unused_addr_lsb = ALUResult_i[1:0];

  // Next-state and transaction bookkeeping
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (acc) begin
          addr_d  = {ALUResult_i[31:2], 2'b00};
          wdata_d = WRData_i;
          we_d    = MemWrite_i;
          req_d   = 1'b1;
          cnt_d   = '0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (mem_ack_i) begin
          req_d = 1'b0;
          if (!we_q) rdata_d = mem_rdata_i;
          state_d = ST_DONE;
        end else if (TO_EN && (cnt_q == TO_LAST)) begin
          req_d   = 1'b0;
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // MEM_WB has no enable, so stalled cycles must present a bubble
  assign stall_o     = ((state_q == ST_IDLE) & acc) | (state_q == ST_BUSY);
  assign RegWrite_o  = RegWrite_i & ~stall_o;
  assign MemToReg_o  = MemToReg_i & ~stall_o;
  assign RDData_o    = rdata_q;
  assign mem_req_o   = req_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign bus_err_o   = err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl (built with TIMEOUT=4).
module tb_mem_access_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        MemRead_i, MemWrite_i, RegWrite_i, MemToReg_i, mem_ack_i;
  logic [31:0] ALUResult_i, WRData_i, mem_rdata_i;
  logic        mem_req_o, mem_we_o, RegWrite_o, MemToReg_o, stall_o, bus_err_o;
  logic [31:0] mem_addr_o, mem_wdata_o, RDData_o;

  int errors = 0;
  int checks = 0;

  mem_access_ctrl #(.TIMEOUT(4), .TO_W(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
    .ALUResult_i(ALUResult_i), .WRData_i(WRData_i),
    .RegWrite_i(RegWrite_i), .MemToReg_i(MemToReg_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
    .RDData_o(RDData_o), .RegWrite_o(RegWrite_o), .MemToReg_o(MemToReg_o),
    .stall_o(stall_o), .bus_err_o(bus_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic clear_inputs();
    MemRead_i = 0; MemWrite_i = 0; RegWrite_i = 0; MemToReg_i = 0;
    ALUResult_i = 0; WRData_i = 0; mem_ack_i = 0; mem_rdata_i = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk_i); #1;
  endtask

  // Drives one memory instruction from its IDLE cycle; acks on the ack_at-th
  // request cycle and returns in the DONE cycle (mid-cycle) with inputs held.
  task automatic run_access(input logic rd, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] rdata,
                            input int ack_at, output int req_n, output int stall_n,
                            output int rw_stall, output logic we_seen,
                            output logic [31:0] addr_seen, output logic [31:0] wdata_seen);
    MemRead_i = rd; MemWrite_i = wr; ALUResult_i = addr; WRData_i = wdata;
    RegWrite_i = rd; MemToReg_i = rd;
    req_n = 0; stall_n = 0; rw_stall = 0; we_seen = 1'bx;
    addr_seen = 'x; wdata_seen = 'x;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (mem_req_o) begin
        req_n++;
        we_seen = mem_we_o; addr_seen = mem_addr_o; wdata_seen = mem_wdata_o;
      end
      mem_ack_i   = mem_req_o && (req_n == ack_at);
      mem_rdata_i = mem_ack_i ? rdata : 32'h0;
      #4;
      if (stall_o) begin
        stall_n++;
        if (RegWrite_o) rw_stall++;
      end else if (cyc > 0) begin
        break;
      end
      next_cycle();
    end
    mem_ack_i = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_i = 1;
    #3;
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", stall_o); end
    checks++; if (RegWrite_o !== 1'b0) begin errors++; $display("FAIL reset_regwrite got=%b exp=0", RegWrite_o); end
    checks++; if (mem_req_o !== 1'b0 || mem_we_o !== 1'b0) begin errors++; $display("FAIL reset_req_we got=%b%b exp=00", mem_req_o, mem_we_o); end
    checks++; if (mem_addr_o !== 32'h0 || mem_wdata_o !== 32'h0) begin errors++; $display("FAIL reset_addr_wdata got=%h/%h exp=0", mem_addr_o, mem_wdata_o); end
    checks++; if (RDData_o !== 32'h0 || bus_err_o !== 1'b0) begin errors++; $display("FAIL reset_rdata_err got=%h/%b exp=0", RDData_o, bus_err_o); end
    next_cycle();
    rst_i = 0;
    next_cycle();
  endtask

  task automatic test_load();
    int r, s, w; logic we; logic [31:0] a, d;
    run_access(1, 0, 32'h0000_1006, 32'h0, 32'hDEAD_BEEF, 1, r, s, w, we, a, d);
    checks++; if (r != 1) begin errors++; $display("FAIL load_req_cycles got=%0d exp=1", r); end
    checks++; if (s != 2) begin errors++; $display("FAIL load_stall_cycles got=%0d exp=2", s); end
    checks++; if (w != 0) begin errors++; $display("FAIL load_regwrite_in_stall got=%0d exp=0", w); end
    checks++; if (a !== 32'h0000_1004) begin errors++; $display("FAIL load_addr got=%h exp=00001004", a); end
    checks++; if (we !== 1'b0) begin errors++; $display("FAIL load_we got=%b exp=0", we); end
    checks++; if (RDData_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL load_rdata got=%h exp=deadbeef", RDData_o); end
    checks++; if (RegWrite_o !== 1'b1 || MemToReg_o !== 1'b1) begin errors++; $display("FAIL load_done_wb got=%b%b exp=11", RegWrite_o, MemToReg_o); end
    checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL load_done_req got=%b exp=0", mem_req_o); end
    clear_inputs();
    next_cycle();
  endtask

  task automatic test_store_wait();
    int r, s, w; logic we; logic [31:0] a, d;
    run_access(0, 1, 32'h0000_2000, 32'h1234_5678, 32'hFFFF_0000, 4, r, s, w, we, a, d);
    checks++; if (r != 4) begin errors++; $display("FAIL store_req_cycles got=%0d exp=4", r); end
    checks++; if (s != 5) begin errors++; $display("FAIL store_stall_cycles got=%0d exp=5", s); end
    checks++; if (we !== 1'b1) begin errors++; $display("FAIL store_we got=%b exp=1", we); end
    checks++; if (d !== 32'h1234_5678) begin errors++; $display("FAIL store_wdata got=%h exp=12345678", d); end
    checks++; if (RDData_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL store_rdata_kept got=%h exp=deadbeef", RDData_o); end
    checks++; if (bus_err_o !== 1'b0) begin errors++; $display("FAIL store_no_timeout got=%b exp=0", bus_err_o); end
    clear_inputs();
    next_cycle();
  endtask

  task automatic test_back_to_back();
    int r, s, w; logic we; logic [31:0] a, d;
    RegWrite_i = 1; MemToReg_i = 0; mem_ack_i = 1; mem_rdata_i = 32'hBAD0_0BAD;
    #1;
    checks++; if (stall_o !== 1'b0 || RegWrite_o !== 1'b1) begin errors++; $display("FAIL alu_passthru got=%b/%b exp=0/1", stall_o, RegWrite_o); end
    next_cycle();
    mem_ack_i = 0; mem_rdata_i = 0;
    checks++; if (mem_req_o !== 1'b0 || RDData_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL stray_ack got=%b/%h exp=0/deadbeef", mem_req_o, RDData_o); end
    run_access(1, 0, 32'h0000_3000, 32'h0, 32'hCAFE_F00D, 1, r, s, w, we, a, d);
    checks++; if (r != 1 || s != 2) begin errors++; $display("FAIL b2b_load got=%0d/%0d exp=1/2", r, s); end
    checks++; if (RDData_o !== 32'hCAFE_F00D) begin errors++; $display("FAIL b2b_rdata got=%h exp=cafef00d", RDData_o); end
    clear_inputs();
    next_cycle();
    #3;
    checks++; if (mem_req_o !== 1'b0 || stall_o !== 1'b0) begin errors++; $display("FAIL b2b_idle got=%b/%b exp=0/0", mem_req_o, stall_o); end
    next_cycle();
  endtask

  task automatic test_timeout();
    int r, s, w; logic we; logic [31:0] a, d;
    run_access(1, 0, 32'h0000_4000, 32'h0, 32'h0, 100, r, s, w, we, a, d);
    checks++; if (r != 4) begin errors++; $display("FAIL timeout_req_cycles got=%0d exp=4", r); end
    checks++; if (s != 5) begin errors++; $display("FAIL timeout_stall_cycles got=%0d exp=5", s); end
    checks++; if (RDData_o !== 32'h0 || bus_err_o !== 1'b1) begin errors++; $display("FAIL timeout_done got=%h/%b exp=0/1", RDData_o, bus_err_o); end
    clear_inputs();
    next_cycle();
    run_access(1, 0, 32'h0000_4004, 32'h0, 32'h0000_55AA, 1, r, s, w, we, a, d);
    checks++; if (RDData_o !== 32'h0000_55AA || bus_err_o !== 1'b1) begin errors++; $display("FAIL timeout_sticky got=%h/%b exp=000055aa/1", RDData_o, bus_err_o); end
    clear_inputs();
    next_cycle();
  endtask

  task automatic test_reset_mid_busy();
    int r, s, w; logic we; logic [31:0] a, d;
    MemRead_i = 1; ALUResult_i = 32'h0000_5000; RegWrite_i = 1;
    next_cycle();
    checks++; if (mem_req_o !== 1'b1 || stall_o !== 1'b1) begin errors++; $display("FAIL midbusy_pre got=%b/%b exp=1/1", mem_req_o, stall_o); end
    #2;
    clear_inputs();
    rst_i = 1;
    #1;
    checks++; if (mem_req_o !== 1'b0 || stall_o !== 1'b0 || bus_err_o !== 1'b0) begin errors++; $display("FAIL midbusy_async got=%b/%b/%b exp=0/0/0", mem_req_o, stall_o, bus_err_o); end
    checks++; if (RegWrite_o !== 1'b0 || RDData_o !== 32'h0) begin errors++; $display("FAIL midbusy_outputs got=%b/%h exp=0/0", RegWrite_o, RDData_o); end
    next_cycle();
    rst_i = 0;
    next_cycle();
    run_access(1, 0, 32'h0000_6003, 32'h0, 32'h0BAD_CAFE, 2, r, s, w, we, a, d);
    checks++; if (r != 2 || s != 3 || a !== 32'h0000_6000) begin errors++; $display("FAIL post_reset_load got=%0d/%0d/%h exp=2/3/00006000", r, s, a); end
    checks++; if (RDData_o !== 32'h0BAD_CAFE) begin errors++; $display("FAIL post_reset_rdata got=%h exp=0badcafe", RDData_o); end
    clear_inputs();
    next_cycle();
  endtask

  task automatic test_read_write_both();
    int r, s, w; logic we; logic [31:0] a, d;
    run_access(1, 1, 32'h0000_7000, 32'hA5A5_A5A5, 32'hBAD0_BAD0, 1, r, s, w, we, a, d);
    checks++; if (we !== 1'b1 || d !== 32'hA5A5_A5A5) begin errors++; $display("FAIL both_we got=%b/%h exp=1/a5a5a5a5", we, d); end
    checks++; if (RDData_o !== 32'h0BAD_CAFE) begin errors++; $display("FAIL both_rdata_kept got=%h exp=0badcafe", RDData_o); end
    clear_inputs();
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_load();
    test_store_wait();
    test_back_to_back();
    test_timeout();
    test_reset_mid_busy();
    test_read_write_both();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- MEM-stage data-memory controller. Sits between the EX_MEM pipeline register and the MEM_WB pipeline register.
- Converts the single-cycle MemRead/MemWrite controls into a req/ack transaction on a variable-latency data-memory port.
- Stalls the pipeline while the transaction is outstanding.
- Presents read data plus gated write-back controls to MEM_WB, so MEM_WB (which has no enable) captures a bubble on every stalled cycle.

Parameters:
- TIMEOUT, 255: maximum BUSY cycles without mem_ack_i before abort. 0 disables the timeout.
- TO_W, 8: width of the timeout counter. Must satisfy TIMEOUT < 2**TO_W.

Ports:
- clk_i  in  1  clock, posedge
- rst_i  in  1  reset, asynchronous, active-high
- MemRead_i  in  1  load request from EX_MEM
- MemWrite_i  in  1  store request from EX_MEM
- ALUResult_i  in  32  effective byte address from EX_MEM
- WRData_i  in  32  store data from EX_MEM
- RegWrite_i  in  1  write-back enable from EX_MEM
- MemToReg_i  in  1  write-back select from EX_MEM
- mem_req_o  out  1  memory request, registered
- mem_we_o  out  1  1 = write, registered
- mem_addr_o  out  32  word address, registered: {addr[31:2],2'b00}
- mem_wdata_o  out  32  store data, registered
- mem_ack_i  in  1  memory completion, one cycle per request
- mem_rdata_i  in  32  read data, valid when mem_ack_i=1
- RDData_o  out  32  load data to MEM_WB RDData_i
- RegWrite_o  out  1  RegWrite_i gated by ~stall_o
- MemToReg_o  out  1  MemToReg_i gated by ~stall_o
- stall_o  out  1  freeze PC, IF_ID, ID_EX, EX_MEM
- bus_err_o  out  1  sticky timeout flag

Behaviour:
- Access is defined as acc = MemRead_i | MemWrite_i.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If acc: latch mem_addr_o, mem_wdata_o and mem_we_o = MemWrite_i; set mem_req_o=1; clear the counter; next state BUSY.
  - Else remain in IDLE.
- BUSY:
  - mem_req_o and latched address/data/we held stable.
  - On mem_ack_i=1: deassert mem_req_o; if mem_we_o=0 capture mem_rdata_i into rdata_q; next state DONE.
  - Else increment the counter. If TIMEOUT != 0 and the counter reaches TIMEOUT-1 without ack: deassert req, set rdata_q=0, set bus_err_o=1 (sticky until reset), next state DONE.
- DONE: unconditional next state IDLE. The instruction leaves MEM at the end of this cycle.
- stall_o (combinational) = (IDLE & acc) | BUSY. It is 0 in DONE and in IDLE when acc=0.
- RegWrite_o = RegWrite_i & ~stall_o.
- MemToReg_o = MemToReg_i & ~stall_o.
- RDData_o = rdata_q at all times. Write-back only consumes it in DONE for loads.
- Minimum latency: ack in the first BUSY cycle gives 3 cycles per memory instruction (IDLE, BUSY, DONE) and 2 stall cycles. Each extra wait cycle adds one stall cycle.
- Non-memory instructions pass through with zero stall. Controls go unmodified, same cycle.
- MemRead_i and MemWrite_i both high: treated as a write (mem_we_o=1). rdata_q is unchanged.
- Store ack: rdata_q is unchanged.
- mem_ack_i outside BUSY is ignored; no state change.
- Back-to-back memory instructions: DONE always returns to IDLE, which then sees the new acc. There is no overlap and exactly one request per instruction.
- Misaligned address: low two bits are dropped. No error is raised.
- Reset (async, any state, including mid-BUSY) clears:
  - state to IDLE
  - mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, rdata_q, counter, bus_err_o to 0
- With inputs from EX_MEM at their reset value 0, stall_o = 0 and RegWrite_o = 0 while rst_i=1.

Test Plan:
1. Load, ack in first BUSY cycle: MemRead_i=1, ALUResult_i=0x0000_1006, RegWrite_i=1, mem_rdata_i=0xDEAD_BEEF -> mem_addr_o=0x0000_1004, mem_we_o=0; stall_o high 2 cycles; DONE cycle gives RDData_o=0xDEAD_BEEF and RegWrite_o=1; RegWrite_o=0 during both stall cycles.
2. Store with 3 wait cycles: MemWrite_i=1, WRData_i=0x1234_5678 -> mem_req_o high 4 cycles with mem_we_o=1 and mem_wdata_o=0x1234_5678; stall_o high 5 cycles; RDData_o keeps its prior value.
3. ALU op then load back-to-back: acc=0 with RegWrite_i=1 -> RegWrite_o=1 same cycle, no stall; next instruction a load -> exactly one mem_req_o pulse sequence; a stray mem_ack_i in IDLE is ignored.
4. Timeout, TIMEOUT=4, ack never asserted -> req drops after 4 BUSY cycles; DONE gives RDData_o=0 and bus_err_o=1; bus_err_o stays 1 through later successful accesses until reset.
5. Reset mid-BUSY: assert rst_i asynchronously between clock edges -> mem_req_o, stall_o and bus_err_o go 0 without a clock edge; after release, a new load completes normally.
6. MemRead_i=MemWrite_i=1 -> mem_we_o=1 and rdata_q is unchanged.
